mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// CPU memory-bus controller: decodes CPU requests to on-chip RAM or an IO
// region, handles IO wait/timeout, and reports bus errors with a sticky
// address and a saturating error count.
module mem_bus_ctrl #(
    parameter int unsigned RAM_AW    = 12,
    parameter logic [3:0]  IO_NIBBLE = 4'hF,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              resetn,
    // CPU side
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    // on-chip RAM
    output logic              ram_cs,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    // IO region
    output logic              io_valid,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    output logic [3:0]        io_wstrb,
    input  logic              io_ready,
    input  logic [31:0]       io_rdata,
    // error reporting
    output logic              bus_err,
    output logic [31:0]       err_addr,
    output logic [7:0]        err_count
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned RAM_LSB = RAM_AW + 2;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_RD  = 2'd1,
        IO_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   to_cnt;

    logic accept;
    logic ram_hit;
    logic io_hit;
    logic dec_err;
    logic to_err;

    // Request decode and the combinational RAM strobe, only live in IDLE
    always_comb begin
        accept  = (state == IDLE) && mem_valid;
        ram_hit = (mem_addr[31:28] == 4'h0) &&
                  ((mem_addr[27:0] >> RAM_LSB) == 28'd0);
        io_hit  = (mem_addr[31:28] == IO_NIBBLE) && !mem_instr;
        dec_err = accept && !ram_hit && !io_hit;
        to_err  = (state == IO_WAIT) && !io_ready && (to_cnt == TO_LAST);
        ram_cs  = accept && ram_hit;
        ram_we  = ram_cs ? mem_wstrb : 4'h0;
    end

    assign ram_addr  = mem_addr[RAM_AW+1:2];
    assign ram_wdata = mem_wdata;

    // Transaction FSM with registered CPU/IO handshake outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            bus_err   <= 1'b0;
            io_valid  <= 1'b0;
            io_addr   <= 32'd0;
            io_wdata  <= 32'd0;
            io_wstrb  <= 4'h0;
            to_cnt    <= '0;
        end else begin
            mem_ready <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (ram_hit) begin
                            if (mem_wstrb != 4'h0) begin
                                mem_ready <= 1'b1;
                                state     <= RESP;
                            end else begin
                                state     <= RAM_RD;
                            end
                        end else if (io_hit) begin
                            io_valid <= 1'b1;
                            io_addr  <= mem_addr;
                            io_wdata <= mem_wdata;
                            io_wstrb <= mem_wstrb;
                            to_cnt   <= '0;
                            state    <= IO_WAIT;
                        end else begin
                            mem_rdata <= 32'd0;
                            mem_ready <= 1'b1;
                            bus_err   <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                RAM_RD: begin
                    mem_rdata <= ram_rdata;
                    mem_ready <= 1'b1;
                    state     <= RESP;
                end
                IO_WAIT: begin
                    if (io_ready) begin
                        mem_rdata <= io_rdata;
                        io_valid  <= 1'b0;
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        io_valid  <= 1'b0;
                        mem_rdata <= 32'd0;
                        mem_ready <= 1'b1;
                        bus_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        to_cnt    <= to_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Error log: last failing address and a saturating count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_addr  <= 32'd0;
            err_count <= '0;
        end else if (dec_err || to_err) begin
            err_addr <= dec_err ? mem_addr : io_addr;
            if (err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: transaction-level reference model plus a
// per-cycle output comparator, with directed and random traffic.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

    localparam int unsigned RAM_AW  = 6;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned WORDS   = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              mem_valid = 1'b0;
    logic              mem_instr = 1'b0;
    logic [31:0]       mem_addr = 32'd0;
    logic [31:0]       mem_wdata = 32'd0;
    logic [3:0]        mem_wstrb = 4'h0;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic              ram_cs;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;
    logic              io_valid;
    logic [31:0]       io_addr;
    logic [31:0]       io_wdata;
    logic [3:0]        io_wstrb;
    logic              io_ready = 1'b0;
    logic [31:0]       io_rdata = 32'd0;
    logic              bus_err;
    logic [31:0]       err_addr;
    logic [7:0]        err_count;

    mem_bus_ctrl #(.RAM_AW(RAM_AW), .IO_NIBBLE(4'hF), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_valid(io_valid), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_wstrb(io_wstrb), .io_ready(io_ready), .io_rdata(io_rdata),
        .bus_err(bus_err), .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bench-side RAM device: byte-enable write, registered read
    logic [31:0] ram_dev [WORDS];
    logic [31:0] ref_mem [WORDS];

    always @(posedge clk) begin
        if (ram_cs) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_dev[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= ram_dev[ram_addr];
        end
    end

    // Reference-model expectations for the transaction in flight
    int          exp_ready_cyc = -1;
    logic        exp_err = 1'b0;
    logic        upd_rdata = 1'b0;
    logic [31:0] exp_rdata_nx = 32'd0;
    logic [31:0] exp_eaddr_nx = 32'd0;
    logic [7:0]  exp_ecnt_nx = 8'd0;
    int          ram_cyc = -1;
    logic [3:0]  exp_we = 4'h0;
    logic [31:0] exp_raddr = 32'd0;
    logic [31:0] exp_rwdata = 32'd0;
    int          io_lo = -1;
    int          io_hi = -1;
    logic [31:0] exp_io_addr = 32'd0;
    logic [31:0] exp_io_wdata = 32'd0;
    logic [3:0]  exp_io_wstrb = 4'h0;
    logic [31:0] m_rdata = 32'd0;
    logic [31:0] m_eaddr = 32'd0;
    logic [7:0]  m_ecnt = 8'd0;

    // Observations captured by the driver for literal checks
    int          c_lat;
    int          c_iocnt;
    logic [31:0] c_rdata;
    logic        c_err;
    logic        c_cs;
    logic [3:0]  c_we;
    logic [31:0] c_raddr;
    logic [31:0] c_ioaddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparator against the model
    initial begin
        logic io_exp;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_mem_ready", 32'(mem_ready), 32'd0);
                chk("rst_bus_err",   32'(bus_err),   32'd0);
                chk("rst_io_valid",  32'(io_valid),  32'd0);
                chk("rst_mem_rdata", mem_rdata,      32'd0);
                chk("rst_io_addr",   io_addr,        32'd0);
                chk("rst_io_wdata",  io_wdata,       32'd0);
                chk("rst_io_wstrb",  32'(io_wstrb),  32'd0);
                chk("rst_err_addr",  err_addr,       32'd0);
                chk("rst_err_count", 32'(err_count), 32'd0);
            end else begin
                if (cyc == exp_ready_cyc) begin
                    if (upd_rdata) m_rdata = exp_rdata_nx;
                    m_eaddr = exp_eaddr_nx;
                    m_ecnt  = exp_ecnt_nx;
                end
                chk("mem_ready", 32'(mem_ready), 32'(cyc == exp_ready_cyc));
                chk("bus_err",   32'(bus_err),   32'((cyc == exp_ready_cyc) && exp_err));
                chk("mem_rdata", mem_rdata,      m_rdata);
                chk("err_addr",  err_addr,       m_eaddr);
                chk("err_count", 32'(err_count), 32'(m_ecnt));
                chk("ram_cs",    32'(ram_cs),    32'(cyc == ram_cyc));
                if (cyc == ram_cyc) begin
                    chk("ram_we",   32'(ram_we),   32'(exp_we));
                    chk("ram_addr", 32'(ram_addr), exp_raddr);
                    if (exp_we != 4'h0) chk("ram_wdata", ram_wdata, exp_rwdata);
                end else begin
                    chk("ram_we_idle", 32'(ram_we), 32'd0);
                end
                io_exp = (io_lo >= 0) && (cyc >= io_lo) && (cyc <= io_hi);
                chk("io_valid", 32'(io_valid), 32'(io_exp));
                if (io_exp) begin
                    chk("io_addr",  io_addr,        exp_io_addr);
                    chk("io_wdata", io_wdata,       exp_io_wdata);
                    chk("io_wstrb", 32'(io_wstrb),  32'(exp_io_wstrb));
                end
            end
        end
    end

    task automatic drive_garbage(input logic valid);
        mem_valid = valid;
        mem_instr = 1'($urandom);
        mem_addr  = valid ? 32'($urandom_range(0, WORDS*4-1)) : $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
    endtask

    task automatic step_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive_garbage(1'b0);
            io_ready = 1'($urandom);
            io_rdata = $urandom;
        end
    endtask

    // One CPU transaction, presented for exactly one cycle; the model
    // predicts its full effect from the decode rules.
    task automatic issue(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int d, input logic [31:0] iord,
                         input logic garbage);
        int a, lat_exp, word;
        logic rh, ih, err;
        a   = cyc;
        rh  = addr < 32'(WORDS*4);
        ih  = (addr[31:28] == 4'hF) && !instr;
        err = 1'b0;
        upd_rdata    = 1'b1;
        exp_eaddr_nx = m_eaddr;
        exp_ecnt_nx  = m_ecnt;
        lat_exp      = 1;
        if (rh) begin
            word       = int'(addr / 4);
            ram_cyc    = a;
            exp_we     = wstrb;
            exp_raddr  = 32'(word);
            exp_rwdata = wdata;
            if (wstrb != 4'h0) begin
                lat_exp   = 1;
                upd_rdata = 1'b0;
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) ref_mem[word][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                lat_exp      = 2;
                exp_rdata_nx = ref_mem[word];
            end
        end else if (ih) begin
            io_lo        = a + 1;
            exp_io_addr  = addr;
            exp_io_wdata = wdata;
            exp_io_wstrb = wstrb;
            if (d <= int'(TIMEOUT) - 1) begin
                lat_exp      = d + 2;
                io_hi        = a + 1 + d;
                exp_rdata_nx = iord;
            end else begin
                lat_exp = int'(TIMEOUT) + 1;
                io_hi   = a + int'(TIMEOUT);
                err     = 1'b1;
            end
        end else begin
            err = 1'b1;
        end
        if (err) begin
            exp_rdata_nx = 32'd0;
            exp_eaddr_nx = addr;
            exp_ecnt_nx  = (m_ecnt == 8'hFF) ? 8'hFF : m_ecnt + 8'd1;
        end
        exp_err       = err;
        exp_ready_cyc = a + lat_exp;

        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        if (ih) io_ready = 1'b0;
        #1;
        c_cs    = ram_cs;
        c_we    = ram_we;
        c_raddr = 32'(ram_addr);
        c_lat   = -1;
        c_iocnt = 0;
        c_rdata = 32'd0;
        c_err   = 1'b0;
        c_ioaddr = 32'd0;
        for (int i = 1; i <= lat_exp + 1; i++) begin
            @(posedge clk); #1;
            if (mem_ready && c_lat < 0) begin
                c_lat   = i;
                c_rdata = mem_rdata;
                c_err   = bus_err;
            end
            if (io_valid) c_iocnt++;
            if (i == 1) c_ioaddr = io_addr;
            drive_garbage(garbage && (i == lat_exp));
            if (ih && (i == d + 1)) begin
                io_ready = 1'b1;
                io_rdata = iord;
            end else if (ih) begin
                io_ready = 1'b0;
                io_rdata = $urandom;
            end else begin
                io_ready = 1'($urandom);
                io_rdata = $urandom;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, addr;
        int sel, d;
        for (int i = 0; i < int'(WORDS); i++) begin
            v = $urandom;
            ram_dev[i] = v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        step_idle(2);

        // RAM write
        issue(1'b0, 32'h0000_0010, 32'hAABB_CCDD, 4'b0011, 0, 32'd0, 1'b0);
        chk("lit_wr_cs",   32'(c_cs), 32'd1);
        chk("lit_wr_we",   32'(c_we), 32'h3);
        chk("lit_wr_addr", c_raddr,   32'd4);
        chk("lit_wr_lat",  32'(c_lat), 32'd1);
        chk("lit_wr_mem",  32'(ram_dev[4][15:0]), 32'h0000_CCDD);

        // RAM read
        ram_dev[4] = 32'h1234_5678;
        ref_mem[4] = 32'h1234_5678;
        issue(1'b0, 32'h0000_0010, 32'd0, 4'b0000, 0, 32'd0, 1'b0);
        chk("lit_rd_lat",   32'(c_lat), 32'd2);
        chk("lit_rd_rdata", c_rdata,    32'h1234_5678);
        chk("lit_rd_err",   32'(c_err), 32'd0);

        // IO read answered on the third wait cycle
        issue(1'b0, 32'hF000_0004, 32'd0, 4'b0000, 2, 32'hCAFE_0001, 1'b0);
        chk("lit_io_addr",  c_ioaddr,   32'hF000_0004);
        chk("lit_io_lat",   32'(c_lat), 32'd4);
        chk("lit_io_rdata", c_rdata,    32'hCAFE_0001);
        chk("lit_io_err",   32'(c_err), 32'd0);

        // IO answered in the last possible cycle beats the timeout
        issue(1'b0, 32'hF000_0020, 32'd0, 4'b0000, 15, 32'h0BAD_F00D, 1'b0);
        chk("lit_io_last_lat",   32'(c_lat), 32'd17);
        chk("lit_io_last_err",   32'(c_err), 32'd0);
        chk("lit_io_last_rdata", c_rdata,    32'h0BAD_F00D);

        // IO timeout
        issue(1'b0, 32'hF000_0008, 32'h5555_AAAA, 4'b1111, 1000, 32'd0, 1'b0);
        chk("lit_to_iocnt", 32'(c_iocnt), 32'd16);
        chk("lit_to_lat",   32'(c_lat),   32'd17);
        chk("lit_to_err",   32'(c_err),   32'd1);
        chk("lit_to_rdata", c_rdata,      32'd0);
        chk("lit_to_eaddr", err_addr,     32'hF000_0008);
        chk("lit_to_ecnt",  32'(err_count), 32'd1);

        // Reset while waiting on IO
        io_lo         = cyc + 1;
        io_hi         = cyc + 100000;
        exp_io_addr   = 32'hF000_000C;
        exp_io_wdata  = 32'h0000_1111;
        exp_io_wstrb  = 4'hF;
        exp_ready_cyc = -1;
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'hF000_000C;
        mem_wdata = 32'h0000_1111; mem_wstrb = 4'hF; io_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive_garbage(1'b0);
            io_ready = 1'b0;
        end
        #2;
        resetn  = 1'b0;
        io_lo   = -1;
        io_hi   = -1;
        m_rdata = 32'd0;
        m_eaddr = 32'd0;
        m_ecnt  = 8'd0;
        #1;
        chk("lit_rst_io_valid",  32'(io_valid),  32'd0);
        chk("lit_rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("lit_rst_ecnt",      32'(err_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        step_idle(4);
        issue(1'b0, 32'h0000_0010, 32'd0, 4'b0000, 0, 32'd0, 1'b0);
        chk("lit_rst_rd_lat",   32'(c_lat), 32'd2);
        chk("lit_rst_rd_rdata", c_rdata,    32'h1234_5678);

        // Unmapped address and instruction fetch from IO
        issue(1'b0, 32'h2000_0000, 32'd0, 4'b0000, 0, 32'd0, 1'b1);
        chk("lit_um_lat", 32'(c_lat), 32'd1);
        chk("lit_um_err", 32'(c_err), 32'd1);
        issue(1'b1, 32'hF000_0000, 32'd0, 4'b0000, 0, 32'd0, 1'b1);
        chk("lit_if_lat",   32'(c_lat), 32'd1);
        chk("lit_if_err",   32'(c_err), 32'd1);
        chk("lit_if_ecnt",  32'(err_count), 32'd2);
        chk("lit_if_eaddr", err_addr, 32'hF000_0000);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            sel  = $urandom_range(0, 9);
            addr = 32'($urandom_range(0, WORDS*4-1));
            v    = $urandom;
            d    = 0;
            case (sel)
                0, 1, 2: issue(1'($urandom), addr, v, 4'($urandom_range(1, 15)), 0, 32'd0, 1'($urandom));
                3, 4:    issue(1'($urandom), addr, v, 4'h0, 0, 32'd0, 1'($urandom));
                5, 6, 7: begin
                    case ($urandom_range(0, 5))
                        0: d = int'(TIMEOUT) - 1;
                        1: d = int'(TIMEOUT) - 2;
                        2: d = int'(TIMEOUT);
                        3: d = 1000;
                        default: d = $urandom_range(0, 6);
                    endcase
                    addr = {4'hF, 28'($urandom)};
                    issue(1'b0, addr, v, 4'($urandom), d, $urandom, 1'($urandom));
                end
                8: begin
                    if ($urandom_range(0, 1) == 0)
                        addr = {4'h0, 28'($urandom) | 28'h000_0100};
                    else
                        addr = {4'($urandom_range(1, 14)), 28'($urandom)};
                    issue(1'($urandom), addr, v, 4'($urandom), 0, 32'd0, 1'($urandom));
                end
                default: begin
                    addr = {4'hF, 28'($urandom)};
                    issue(1'b1, addr, v, 4'($urandom), 0, 32'd0, 1'($urandom));
                end
            endcase
            if ($urandom_range(0, 3) == 0) step_idle($urandom_range(1, 2));
        end

        // Error counter saturation
        for (int n = 0; n < 260; n++)
            issue(1'b0, {4'h3, 28'($urandom)}, 32'd0, 4'h0, 0, 32'd0, 1'b0);
        chk("lit_sat_ecnt", 32'(err_count), 32'h0000_00FF);
        step_idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
